// File: rtl/mem_line_model.sv
// Line-granular backing memory. Whole lines are written beat by beat over req_data
// and read lines stream back on resp after a fixed latency; one request in flight.
module mem_line_model #(
    parameter int ADDR_BITS    = 26,
    parameter int TAG_BITS     = 5,
    parameter int DATA_BITS    = 128,
    parameter int BEATS        = 4,
    parameter int DEPTH_LINES  = 1024,
    parameter int READ_LATENCY = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_cmd_valid,
    output logic                 req_cmd_ready,
    input  logic                 req_cmd_rw,
    input  logic [ADDR_BITS-1:0] req_cmd_addr,
    input  logic [TAG_BITS-1:0]  req_cmd_tag,
    input  logic                 req_data_valid,
    output logic                 req_data_ready,
    input  logic [DATA_BITS-1:0] req_data_bits,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [TAG_BITS-1:0]  resp_tag,
    output logic [DATA_BITS-1:0] resp_data,
    output logic                 oob_error
);

    localparam int IDX_BITS  = $clog2(DEPTH_LINES);
    localparam int BEAT_W    = $clog2(BEATS);
    localparam int LAT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int MEM_WORDS = DEPTH_LINES * BEATS;

    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(READ_LATENCY - 1);
    localparam logic [BEAT_W-1:0] BEAT0     = '0;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, READ_SEND} state_t;

    typedef struct packed {
        logic [IDX_BITS-1:0] idx;
        logic [TAG_BITS-1:0] tag;
    } line_cmd_t;

    state_t              state;
    line_cmd_t           cur;
    logic [BEAT_W-1:0]   beat;
    logic [LAT_W-1:0]    lat_cnt;
    logic [DATA_BITS-1:0] mem [MEM_WORDS];

    logic                cmd_fire;
    logic                data_fire;
    logic                resp_fire;
    logic                last_beat;
    logic                cmd_oob;
    logic [IDX_BITS-1:0] cmd_idx;
    logic [BEAT_W-1:0]   beat_nxt;

    assign cmd_fire  = req_cmd_valid && req_cmd_ready;
    assign data_fire = req_data_valid && req_data_ready;
    assign resp_fire = resp_valid && resp_ready;
    assign last_beat = (beat == BEAT_LAST);
    assign beat_nxt  = beat + BEAT_W'(1);
    // High address bits are dropped for indexing, so anything above them is out of range.
    assign cmd_idx   = req_cmd_addr[IDX_BITS-1:0];
    assign cmd_oob   = (req_cmd_addr >> IDX_BITS) != '0;

    // Storage has no reset; a write is gated by req_data_ready, which reset clears.
    always_ff @(posedge clk) begin
        if (data_fire)
            mem[{cur.idx, beat}] <= req_data_bits;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cur            <= '0;
            beat           <= '0;
            lat_cnt        <= '0;
            req_cmd_ready  <= 1'b0;
            req_data_ready <= 1'b0;
            resp_valid     <= 1'b0;
            resp_tag       <= '0;
            resp_data      <= '0;
            oob_error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        req_cmd_ready <= 1'b0;
                        cur.idx       <= cmd_idx;
                        cur.tag       <= req_cmd_tag;
                        beat          <= '0;
                        if (cmd_oob)
                            oob_error <= 1'b1;
                        if (req_cmd_rw) begin
                            req_data_ready <= 1'b1;
                            state          <= WRITE;
                        end else if (READ_LATENCY == 1) begin
                            resp_valid <= 1'b1;
                            resp_tag   <= req_cmd_tag;
                            resp_data  <= mem[{cmd_idx, BEAT0}];
                            state      <= READ_SEND;
                        end else begin
                            lat_cnt <= LAT_LOAD;
                            state   <= READ_WAIT;
                        end
                    end
                end
                WRITE: begin
                    if (data_fire) begin
                        beat <= beat_nxt;
                        if (last_beat) begin
                            req_data_ready <= 1'b0;
                            req_cmd_ready  <= 1'b1;
                            state          <= IDLE;
                        end
                    end
                end
                READ_WAIT: begin
                    // Loaded with LATENCY-1 at acceptance; beat 0 is registered as it hits 1.
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    if (lat_cnt == LAT_W'(1)) begin
                        resp_valid <= 1'b1;
                        resp_tag   <= cur.tag;
                        resp_data  <= mem[{cur.idx, BEAT0}];
                        state      <= READ_SEND;
                    end
                end
                READ_SEND: begin
                    if (resp_fire) begin
                        beat <= beat_nxt;
                        if (last_beat) begin
                            resp_valid    <= 1'b0;
                            req_cmd_ready <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            resp_data <= mem[{cur.idx, beat_nxt}];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_model.sv
// Scoreboard bench for mem_line_model: a line-keyed reference memory feeds an
// expected-beat queue; a negedge monitor checks handshakes, latency and payloads.
module tb_mem_line_model;

    localparam int ADDR_BITS = 26;
    localparam int TAG_BITS  = 5;
    localparam int DATA_BITS = 128;
    localparam int BEATS     = 4;
    localparam int DEPTH     = 1024;
    localparam int LAT       = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 req_cmd_valid;
    logic                 req_cmd_ready;
    logic                 req_cmd_rw;
    logic [ADDR_BITS-1:0] req_cmd_addr;
    logic [TAG_BITS-1:0]  req_cmd_tag;
    logic                 req_data_valid;
    logic                 req_data_ready;
    logic [DATA_BITS-1:0] req_data_bits;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [TAG_BITS-1:0]  resp_tag;
    logic [DATA_BITS-1:0] resp_data;
    logic                 oob_error;

    mem_line_model #(
        .ADDR_BITS(ADDR_BITS), .TAG_BITS(TAG_BITS), .DATA_BITS(DATA_BITS),
        .BEATS(BEATS), .DEPTH_LINES(DEPTH), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_cmd_valid(req_cmd_valid), .req_cmd_ready(req_cmd_ready),
        .req_cmd_rw(req_cmd_rw), .req_cmd_addr(req_cmd_addr), .req_cmd_tag(req_cmd_tag),
        .req_data_valid(req_data_valid), .req_data_ready(req_data_ready),
        .req_data_bits(req_data_bits),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_tag(resp_tag), .resp_data(resp_data), .oob_error(oob_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_BITS-1:0]  tag;
        logic [DATA_BITS-1:0] data;
    } exp_t;

    exp_t                 exp_q [$];
    logic [DATA_BITS-1:0] ref_mem [int];
    logic [DATA_BITS-1:0] wbuf [BEATS];
    int                   wl [$];
    int                   n_cmp = 0;
    int                   n_bad = 0;
    int                   rr_mode = 0;
    bit                   rr_pat [7] = '{1, 0, 0, 1, 0, 1, 1};

    // monitor state
    int                   ncyc, exp_first, beats_seen, wr_beats;
    bit                   in_read, in_write, waiting_first, held, chk_rdy, oob_model, oob_pend;
    logic [TAG_BITS-1:0]  hold_tag;
    logic [DATA_BITS-1:0] hold_data;

    function automatic void chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int key(input int addr, input int b);
        return (addr % DEPTH) * BEATS + b;
    endfunction

    initial begin
        int pi = 0;
        resp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0: begin resp_ready = 1'b1; pi = 0; end
                1: begin resp_ready = rr_pat[pi]; pi = (pi + 1) % 7; end
                default: begin resp_ready = 1'($urandom_range(0, 1)); pi = 0; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            in_read = 0; in_write = 0; waiting_first = 0; held = 0; chk_rdy = 0;
            beats_seen = 0; wr_beats = 0; oob_model = 0; oob_pend = 0; ncyc = 0;
        end else begin
            ncyc++;
            if (oob_pend) begin oob_model = 1'b1; oob_pend = 1'b0; end
            chk("oob_error", oob_error, oob_model);
            if (chk_rdy) begin chk("cmd_ready_after_read", req_cmd_ready, 1); chk_rdy = 0; end
            if (in_read) chk("cmd_ready_low_in_read", req_cmd_ready, 0);
            if (in_write) chk("data_ready_in_write", req_data_ready, 1);
            if (held) begin
                chk("stall_valid", resp_valid, 1);
                chk("stall_tag", resp_tag, hold_tag);
                chk("stall_data", resp_data, hold_data);
                held = 0;
            end
            if (resp_valid) begin
                if (waiting_first) begin chk("read_latency", ncyc, exp_first); waiting_first = 0; end
                if (exp_q.size() == 0) chk("unexpected_beat", resp_valid, 0);
                else begin
                    chk("resp_tag", resp_tag, exp_q[0].tag);
                    chk("resp_data", resp_data, exp_q[0].data);
                    if (resp_ready) begin
                        void'(exp_q.pop_front());
                        beats_seen++;
                        if (beats_seen == BEATS) begin beats_seen = 0; in_read = 0; chk_rdy = 1; end
                    end else begin
                        held = 1; hold_tag = resp_tag; hold_data = resp_data;
                    end
                end
            end
            if (req_data_valid && req_data_ready) begin
                wr_beats++;
                if (wr_beats == BEATS) begin wr_beats = 0; in_write = 0; end
            end
            if (req_cmd_valid && req_cmd_ready) begin
                if (int'(req_cmd_addr) >= DEPTH) oob_pend = 1;
                if (req_cmd_rw) in_write = 1;
                else begin in_read = 1; waiting_first = 1; exp_first = ncyc + LAT; end
            end
        end
    end

    task automatic issue_cmd(input bit rw, input int addr, input int tag);
        int n = 0;
        req_cmd_valid = 1'b1;
        req_cmd_rw    = rw;
        req_cmd_addr  = ADDR_BITS'(addr);
        req_cmd_tag   = TAG_BITS'(tag);
        do begin @(negedge clk); n++; end while (!req_cmd_ready && n < 100);
        chk("cmd_accept_wait", req_cmd_ready, 1);
        @(posedge clk); #1;
        req_cmd_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_cmd_ready", req_cmd_ready, 0);
        chk("rst_data_ready", req_data_ready, 0);
        chk("rst_resp_tag", resp_tag, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_oob", oob_error, 0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("cmd_ready_post_reset", req_cmd_ready, 1);
        @(posedge clk); #1;
    endtask

    // abort_at < 0 writes the whole line; otherwise reset hits while that beat is offered
    task automatic do_write(input int addr, input int tag, input int gap, input int abort_at);
        int n;
        issue_cmd(1'b1, addr, tag);
        for (int b = 0; b < BEATS; b++) begin
            if (b == abort_at) begin
                req_data_valid = 1'b1;
                req_data_bits  = wbuf[b];
                pulse_reset();
                req_data_valid = 1'b0;
                return;
            end
            if (gap > 0 && b > 0) begin
                req_data_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            req_data_valid = 1'b1;
            req_data_bits  = wbuf[b];
            n = 0;
            do begin @(negedge clk); n++; end while (!req_data_ready && n < 100);
            chk("data_accept_wait", req_data_ready, 1);
            if (!req_data_ready) begin req_data_valid = 1'b0; return; end
            ref_mem[key(addr, b)] = wbuf[b];
            @(posedge clk); #1;
            req_data_valid = 1'b0;
        end
    endtask

    task automatic do_read(input int addr, input int tag, input int mode);
        int n = 0;
        rr_mode = mode;
        for (int b = 0; b < BEATS; b++)
            exp_q.push_back('{tag: TAG_BITS'(tag), data: ref_mem[key(addr, b)]});
        issue_cmd(1'b0, addr, tag);
        while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        chk("read_drain", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        req_cmd_valid = 0; req_cmd_rw = 0; req_cmd_addr = '0; req_cmd_tag = '0;
        req_data_valid = 0; req_data_bits = '0;

        repeat (2) @(negedge clk);
        chk("in_rst_cmd_ready", req_cmd_ready, 0);
        chk("in_rst_resp_valid", resp_valid, 0);
        chk("in_rst_resp_data", resp_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) chk("idle_cmd_ready", req_cmd_ready, 1);
            chk("idle_resp_valid", resp_valid, 0);
            chk("idle_data_ready", req_data_ready, 0);
            chk("idle_resp_tag", resp_tag, 0);
            chk("idle_resp_data", resp_data, 0);
        end
        @(posedge clk); #1;

        // basic line write and read-back, then a stalled read
        for (int b = 0; b < BEATS; b++) wbuf[b] = DATA_BITS'(32'hA0 + b);
        do_write(32'h12, 3, 0, -1);
        wl.push_back(32'h12);
        do_read(32'h12, 7, 0);
        do_read(32'h12, 7, 1);

        // data offered in IDLE is ignored
        req_data_valid = 1'b1;
        req_data_bits  = DATA_BITS'(32'hFF);
        repeat (3) begin @(negedge clk); chk("data_ready_idle", req_data_ready, 0); end
        @(posedge clk); #1;
        req_data_valid = 1'b0;

        // gapped write
        for (int b = 0; b < BEATS; b++) wbuf[b] = DATA_BITS'(32'hE0 + b);
        do_write(32'h30, 4, 3, -1);
        wl.push_back(32'h30);
        do_read(32'h30, 5, 2);
        do_read(32'h12, 6, 0);

        // out-of-range write aliases onto line 0x12
        for (int b = 0; b < BEATS; b++) wbuf[b] = DATA_BITS'(32'hB0 + b);
        do_write(32'h412, 8, 0, -1);
        do_read(32'h12, 10, 0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            int a, l;
            if (wl.size() == 0 || $urandom_range(0, 1) == 1) begin
                a = $urandom_range(0, DEPTH - 1);
                for (int b = 0; b < BEATS; b++)
                    wbuf[b] = {$urandom, $urandom, $urandom, $urandom};
                do_write(a, $urandom_range(0, 31), $urandom_range(0, 2), -1);
                wl.push_back(a);
            end else begin
                l = wl[$urandom_range(0, wl.size() - 1)];
                a = l + DEPTH * $urandom_range(0, 3);
                do_read(a, $urandom_range(0, 31), $urandom_range(0, 2));
            end
        end

        // reset during read beat 2, then during write beat 1
        rr_mode = 0;
        for (int b = 0; b < BEATS; b++) wbuf[b] = DATA_BITS'(32'hC0 + b);
        do_write(32'h20, 1, 0, -1);
        chk("oob_sticky", oob_error, 1);
        for (int b = 0; b < BEATS; b++)
            exp_q.push_back('{tag: TAG_BITS'(9), data: ref_mem[key(32'h20, b)]});
        issue_cmd(1'b0, 32'h20, 9);
        n = 0;
        do begin @(posedge clk); n++; end while (beats_seen < 2 && n < 100);
        chk("abort_read_progress", beats_seen, 2);
        #1;
        pulse_reset();
        for (int b = 0; b < BEATS; b++) wbuf[b] = DATA_BITS'(32'hD0 + b);
        do_write(32'h20, 2, 0, 1);
        do_read(32'h20, 4, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
